// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: shares one register-file write port between the ALU and
// load return paths, with load priority, ALU anti-starvation and $zero drop.
module regfile_wb_arbiter #(
    parameter int STARVE_LIMIT = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             alu_valid,
    output logic             alu_ready,
    input  logic [4:0]       alu_reg,
    input  logic [31:0]      alu_data,
    input  logic             mem_valid,
    output logic             mem_ready,
    input  logic [4:0]       mem_reg,
    input  logic [31:0]      mem_data,
    output logic             reg_write,
    output logic [4:0]       write_reg,
    output logic [31:0]      write_data,
    output logic             alu_boost,
    output logic             dropped_r0,
    output logic [CNT_W-1:0] write_count
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    // Handshake: a request transfers on a rising clock edge where its valid
    // and ready are both high. Ready depends only on the two valids and the
    // starvation counter; at most one ready is high, and both are low in reset.

    logic [3:0]       starve_q, starve_d;
    logic             reg_write_q;
    logic [4:0]       write_reg_q;
    logic [31:0]      write_data_q;
    logic             dropped_q;
    logic [CNT_W-1:0] count_q;

    logic             boost;
    logic             alu_grant;
    logic             mem_grant;
    logic             any_grant;
    logic [4:0]       grant_reg;
    logic [31:0]      grant_data;

    always_comb begin
        boost     = alu_valid && mem_valid && (starve_q == LIMIT);
        alu_grant = reset_n && alu_valid && (!mem_valid || boost);
        mem_grant = reset_n && mem_valid && !alu_grant;
        any_grant = alu_grant || mem_grant;
        grant_reg  = alu_grant ? alu_reg  : mem_reg;
        grant_data = alu_grant ? alu_data : mem_data;
    end

    // The counter only measures unbroken waiting; any idle ALU cycle resets it.
    always_comb begin
        starve_d = starve_q;
        if (!alu_valid || alu_grant) begin
            starve_d = 4'd0;
        end else if (starve_q < LIMIT) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            starve_q     <= 4'd0;
            reg_write_q  <= 1'b0;
            write_reg_q  <= 5'd0;
            write_data_q <= 32'd0;
            dropped_q    <= 1'b0;
            count_q      <= '0;
        end else begin
            starve_q    <= starve_d;
            reg_write_q <= 1'b0;
            dropped_q   <= 1'b0;
            if (any_grant) begin
                if (grant_reg != 5'd0) begin
                    reg_write_q  <= 1'b1;
                    write_reg_q  <= grant_reg;
                    write_data_q <= grant_data;
                    count_q      <= count_q + CNT_W'(1);
                end else begin
                    dropped_q <= 1'b1;
                end
            end
        end
    end

    assign alu_ready   = alu_grant;
    assign mem_ready   = mem_grant;
    assign alu_boost   = reset_n && boost;
    assign reg_write   = reg_write_q;
    assign write_reg   = write_reg_q;
    assign write_data  = write_data_q;
    assign dropped_r0  = dropped_q;
    assign write_count = count_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a 4-bit write counter.
module tb_regfile_wb_arbiter;

  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          alu_valid = 1'b0;
  logic          alu_ready;
  logic [4:0]    alu_reg = 5'd0;
  logic [31:0]   alu_data = 32'd0;
  logic          mem_valid = 1'b0;
  logic          mem_ready;
  logic [4:0]    mem_reg = 5'd0;
  logic [31:0]   mem_data = 32'd0;
  logic          reg_write;
  logic [4:0]    write_reg;
  logic [31:0]   write_data;
  logic          alu_boost;
  logic          dropped_r0;
  logic [CW-1:0] write_count;

  int n_cmp = 0;
  int n_fail = 0;

  regfile_wb_arbiter #(.STARVE_LIMIT(3), .CNT_W(CW)) dut (
    .clock(clock), .reset_n(reset_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_reg(mem_reg), .mem_data(mem_data),
    .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
    .alu_boost(alu_boost), .dropped_r0(dropped_r0), .write_count(write_count)
  );

  // clock / reset block
  always #5 clock = ~clock;

  task automatic test_reset();
    alu_valid = 1'b1; mem_valid = 1'b1; alu_reg = 5'd4; mem_reg = 5'd5;
    repeat (2) @(posedge clock);
    #1;
    n_cmp++; if (alu_ready !== 1'b0) begin n_fail++; $display("FAIL reset_alu_ready got %0b want 0", alu_ready); end
    n_cmp++; if (mem_ready !== 1'b0) begin n_fail++; $display("FAIL reset_mem_ready got %0b want 0", mem_ready); end
    n_cmp++; if (reg_write !== 1'b0) begin n_fail++; $display("FAIL reset_reg_write got %0b want 0", reg_write); end
    n_cmp++; if (write_reg !== 5'd0) begin n_fail++; $display("FAIL reset_write_reg got %0d want 0", write_reg); end
    n_cmp++; if (write_data !== 32'd0) begin n_fail++; $display("FAIL reset_write_data got %0h want 0", write_data); end
    n_cmp++; if (dropped_r0 !== 1'b0) begin n_fail++; $display("FAIL reset_dropped got %0b want 0", dropped_r0); end
    n_cmp++; if (write_count !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", write_count); end
    @(negedge clock);
    alu_valid = 1'b0; mem_valid = 1'b0;
    reset_n = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_single_alu();
    @(negedge clock);
    alu_valid = 1'b1; alu_reg = 5'd21; alu_data = 32'h11;
    #1;
    n_cmp++; if (alu_ready !== 1'b1) begin n_fail++; $display("FAIL single_alu_ready got %0b want 1", alu_ready); end
    n_cmp++; if (mem_ready !== 1'b0) begin n_fail++; $display("FAIL single_mem_ready got %0b want 0", mem_ready); end
    @(posedge clock); #1;
    n_cmp++; if (reg_write !== 1'b1) begin n_fail++; $display("FAIL single_reg_write got %0b want 1", reg_write); end
    n_cmp++; if (write_reg !== 5'd21) begin n_fail++; $display("FAIL single_write_reg got %0d want 21", write_reg); end
    n_cmp++; if (write_data !== 32'h11) begin n_fail++; $display("FAIL single_write_data got %0h want 11", write_data); end
    n_cmp++; if (write_count !== 4'd1) begin n_fail++; $display("FAIL single_count got %0d want 1", write_count); end
    @(negedge clock);
    alu_valid = 1'b0;
    @(posedge clock); #1;
    n_cmp++; if (reg_write !== 1'b0) begin n_fail++; $display("FAIL single_idle_reg_write got %0b want 0", reg_write); end
  endtask

  task automatic test_contention();
    @(negedge clock);
    mem_valid = 1'b1; mem_reg = 5'd5; mem_data = 32'hAA;
    alu_valid = 1'b1; alu_reg = 5'd6; alu_data = 32'hBB;
    #1;
    n_cmp++; if ({mem_ready, alu_ready} !== 2'b10) begin n_fail++; $display("FAIL cont_grant1 got %b want 10", {mem_ready, alu_ready}); end
    @(posedge clock); #1;
    n_cmp++; if ({reg_write, write_reg, write_data} !== {1'b1, 5'd5, 32'hAA}) begin
      n_fail++; $display("FAIL cont_write1 got %0b/%0d/%0h want 1/5/aa", reg_write, write_reg, write_data); end
    n_cmp++; if (write_count !== 4'd2) begin n_fail++; $display("FAIL cont_count1 got %0d want 2", write_count); end
    @(negedge clock);
    mem_valid = 1'b0;
    #1;
    n_cmp++; if ({mem_ready, alu_ready} !== 2'b01) begin n_fail++; $display("FAIL cont_grant2 got %b want 01", {mem_ready, alu_ready}); end
    @(posedge clock); #1;
    n_cmp++; if ({reg_write, write_reg, write_data} !== {1'b1, 5'd6, 32'hBB}) begin
      n_fail++; $display("FAIL cont_write2 got %0b/%0d/%0h want 1/6/bb", reg_write, write_reg, write_data); end
    n_cmp++; if (write_count !== 4'd3) begin n_fail++; $display("FAIL cont_count2 got %0d want 3", write_count); end
    @(negedge clock);
    alu_valid = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_starvation();
    logic [4:0] exp_ready;
    logic [4:0] exp_boost;
    exp_ready = 5'b01000;  // bit i set: ALU granted on cycle i
    exp_boost = 5'b01000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      alu_valid = 1'b1; alu_reg = 5'd7; alu_data = 32'h77;
      mem_valid = 1'b1; mem_reg = 5'd8; mem_data = 32'h100 + 32'(i);
      #1;
      n_cmp++; if (alu_ready !== exp_ready[i] || mem_ready !== !exp_ready[i]) begin
        n_fail++; $display("FAIL starve_grant[%0d] got alu=%0b mem=%0b want alu=%0b", i, alu_ready, mem_ready, exp_ready[i]); end
      n_cmp++; if (alu_boost !== exp_boost[i]) begin
        n_fail++; $display("FAIL starve_boost[%0d] got %0b want %0b", i, alu_boost, exp_boost[i]); end
      @(posedge clock); #1;
      n_cmp++; if (write_reg !== (exp_ready[i] ? 5'd7 : 5'd8) || write_data !== (exp_ready[i] ? 32'h77 : 32'h100 + 32'(i))) begin
        n_fail++; $display("FAIL starve_write[%0d] got %0d/%0h", i, write_reg, write_data); end
      n_cmp++; if (write_count !== 4'(4 + i)) begin
        n_fail++; $display("FAIL starve_count[%0d] got %0d want %0d", i, write_count, 4 + i); end
    end
    @(negedge clock);
    alu_valid = 1'b0; mem_valid = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_zero_drop();
    @(negedge clock);
    mem_valid = 1'b1; mem_reg = 5'd0; mem_data = 32'hDEAD;
    #1;
    n_cmp++; if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL zero_ready got %0b want 1", mem_ready); end
    @(posedge clock); #1;
    n_cmp++; if (reg_write !== 1'b0) begin n_fail++; $display("FAIL zero_reg_write got %0b want 0", reg_write); end
    n_cmp++; if (dropped_r0 !== 1'b1) begin n_fail++; $display("FAIL zero_dropped got %0b want 1", dropped_r0); end
    n_cmp++; if (write_count !== 4'd8) begin n_fail++; $display("FAIL zero_count got %0d want 8", write_count); end
    n_cmp++; if (write_reg !== 5'd8 || write_data !== 32'h104) begin
      n_fail++; $display("FAIL zero_hold got %0d/%0h want 8/104", write_reg, write_data); end
    @(negedge clock);
    mem_valid = 1'b0;
    @(posedge clock); #1;
    n_cmp++; if (dropped_r0 !== 1'b0) begin n_fail++; $display("FAIL zero_pulse got %0b want 0", dropped_r0); end
  endtask

  task automatic test_back_to_back_wrap();
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    n_cmp++; if (write_count !== 4'd0) begin n_fail++; $display("FAIL wrap_reset_count got %0d want 0", write_count); end
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 17; i++) begin
      @(negedge clock);
      alu_valid = 1'b1; alu_reg = 5'((i % 31) + 1); alu_data = 32'hC000 + 32'(i);
      @(posedge clock); #1;
      n_cmp++; if (reg_write !== 1'b1 || write_reg !== 5'((i % 31) + 1) || write_data !== 32'hC000 + 32'(i)) begin
        n_fail++; $display("FAIL b2b_write[%0d] got %0b/%0d/%0h", i, reg_write, write_reg, write_data); end
      n_cmp++; if (write_count !== 4'((i + 1) % 16)) begin
        n_fail++; $display("FAIL wrap_count[%0d] got %0d want %0d", i, write_count, (i + 1) % 16); end
    end
    @(negedge clock);
    alu_valid = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_async_reset();
    @(negedge clock);
    alu_valid = 1'b1; alu_reg = 5'd3; alu_data = 32'h33;
    @(posedge clock); #1;
    n_cmp++; if (reg_write !== 1'b1 || write_count !== 4'd2) begin
      n_fail++; $display("FAIL arst_pre got %0b/%0d want 1/2", reg_write, write_count); end
    #1;
    reset_n = 1'b0;
    #1;
    n_cmp++; if (reg_write !== 1'b0) begin n_fail++; $display("FAIL arst_reg_write got %0b want 0", reg_write); end
    n_cmp++; if (write_count !== 4'd0) begin n_fail++; $display("FAIL arst_count got %0d want 0", write_count); end
    n_cmp++; if (alu_ready !== 1'b0 || mem_ready !== 1'b0) begin
      n_fail++; $display("FAIL arst_ready got %0b%0b want 00", alu_ready, mem_ready); end
    @(negedge clock);
    alu_valid = 1'b0;
    reset_n = 1'b1;
    @(negedge clock);
    alu_valid = 1'b1; alu_reg = 5'd9; alu_data = 32'h99;
    @(posedge clock); #1;
    n_cmp++; if ({reg_write, write_reg, write_data} !== {1'b1, 5'd9, 32'h99}) begin
      n_fail++; $display("FAIL arst_after got %0b/%0d/%0h want 1/9/99", reg_write, write_reg, write_data); end
    n_cmp++; if (write_count !== 4'd1) begin n_fail++; $display("FAIL arst_after_count got %0d want 1", write_count); end
    @(negedge clock);
    alu_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_alu();
    test_contention();
    test_starvation();
    test_zero_drop();
    test_back_to_back_wrap();
    test_async_reset();
    repeat (2) @(posedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
